// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port, registered-address RAM between two
// clients (A and B) with round-robin priority, one access per cycle.
// Optional feature macro: RAM_ARB_CLEAR_EN -- when defined, a post-reset sweep
// writes 0 to every RAM word (busy=1) before any grant is issued.
//
// Handshake (both clients): a transfer happens in any cycle where req_x=1 and
// gnt_x=1. gnt_x is combinational in the same cycle as req_x. The client holds
// req/we/addr/wdata stable until granted; dropping req before the grant simply
// withdraws the request. A granted read returns rvalid_x=1 with rdata_x (which
// always mirrors ram_q) exactly one cycle later.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_a,
   input  logic                  req_b,
   input  logic                  we_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  gnt_a,
   output logic                  gnt_b,
   output logic                  rvalid_a,
   output logic                  rvalid_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  busy,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  dbg_state  // 0 = INIT (clear sweep), 1 = RUN
);

   // last_grant encoding: which client was granted most recently
   localparam logic LG_A = 1'b0;
   localparam logic LG_B = 1'b1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic                  w_run;         // grants allowed this cycle
   logic                  w_sweep;       // clear sweep owns the RAM this cycle
   logic [ADDR_WIDTH-1:0] w_sweep_addr;
   logic                  w_gnt_a;
   logic                  w_gnt_b;
   logic                  r_last_grant;
   logic                  r_rvalid_a;
   logic                  r_rvalid_b;

`ifdef RAM_ARB_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;

   // State register and sweep address counter; reset always restarts the sweep at 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_INIT;
         r_clr_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
         end
      end
   end

   // Next state: leave INIT after the last address has been written
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: if (r_clr_cnt == CNT_LAST) w_state_next = ST_RUN;
         default: w_state_next = ST_RUN;
      endcase
   end

   // rst also counts as busy so busy reads 1 from the very first reset cycle
   assign w_run        = (r_state == ST_RUN) && !rst;
   assign w_sweep      = (r_state == ST_INIT) && !rst;
   assign w_sweep_addr = r_clr_cnt;
   assign busy         = (r_state == ST_INIT) || rst;
   assign dbg_state    = r_state;
`else
   // No sweep: the arbiter is always in RUN, only reset blocks grants
   assign w_run        = !rst;
   assign w_sweep      = 1'b0;
   assign w_sweep_addr = '0;
   assign busy         = 1'b0;
   assign dbg_state    = ST_RUN;
`endif

   // Round-robin grant: a sole requester wins, contention goes to the client not granted last
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (w_run) begin
         if (req_a && req_b) begin
            if (r_last_grant == LG_B) begin
               w_gnt_a = 1'b1;
            end else begin
               w_gnt_b = 1'b1;
            end
         end else begin
            w_gnt_a = req_a;
            w_gnt_b = req_b;
         end
      end
   end

   // RAM drive: sweep writes zero, else the granted client's access, else all zero
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
      if (w_sweep) begin
         ram_we   = 1'b1;
         ram_addr = w_sweep_addr;
      end else if (w_gnt_a) begin
         ram_we   = we_a;
         ram_addr = addr_a;
         ram_data = wdata_a;
      end else if (w_gnt_b) begin
         ram_we   = we_b;
         ram_addr = addr_b;
         ram_data = wdata_b;
      end
   end

   // Priority history and read-return tags; the RAM answers one cycle after the address
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= LG_B;
         r_rvalid_a   <= 1'b0;
         r_rvalid_b   <= 1'b0;
      end else begin
         if (w_gnt_a) begin
            r_last_grant <= LG_A;
         end else if (w_gnt_b) begin
            r_last_grant <= LG_B;
         end
         r_rvalid_a <= w_gnt_a && !we_a;
         r_rvalid_b <= w_gnt_b && !we_b;
      end
   end

   assign gnt_a    = w_gnt_a;
   assign gnt_b    = w_gnt_b;
   assign rvalid_a = r_rvalid_a;
   assign rvalid_b = r_rvalid_b;
   assign rdata_a  = ram_q;
   assign rdata_b  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural
// registered-address RAM. Expected grants and read returns are queued as the
// stimulus is issued; a negedge monitor pops and compares them.
// Builds with or without RAM_ARB_CLEAR_EN.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
   localparam int AW = 6;
   localparam int DW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [DW-1:0] wdata_a = '0, wdata_b = '0;
   logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we, dbg_state;
   logic [DW-1:0] rdata_a, rdata_b, ram_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_q = '0;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
      .dbg_state(dbg_state)
   );

   // Registered-address single-port RAM; non-zero power-up so the sweep is visible
   logic [DW-1:0] mem [64] = '{default: 8'hFF};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_gnt_q[$];  // {is_b, we, addr[5:0], data[7:0]}
   logic [8:0]  exp_rd_q[$];   // {is_b, rdata[7:0]}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void exp_gnt(input logic b, input logic we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
      exp_gnt_q.push_back({b, we, a, d});
   endfunction

   function automatic void exp_rd(input logic b, input logic [DW-1:0] d);
      exp_rd_q.push_back({b, d});
   endfunction

   // Monitor: every grant and every read return must match the head of its queue
   always @(negedge clk) begin
      logic [15:0]   eg;
      logic [8:0]    er;
      logic [DW-1:0] rd;
      if (!rst && !busy) begin
         if (gnt_a || gnt_b) begin
            if (exp_gnt_q.size() == 0) begin
               check("unexpected_grant", 32'({gnt_a, gnt_b}), 32'(0));
            end else begin
               eg = exp_gnt_q.pop_front();
               check("grant", 32'({gnt_a, gnt_b, ram_we, ram_addr, ram_data}),
                     32'({~eg[15], eg[15], eg[14:0]}));
            end
         end else begin
            check("idle_drive", 32'({ram_we, ram_addr, ram_data}), 32'(0));
         end
         if (rvalid_a || rvalid_b) begin
            rd = rvalid_b ? rdata_b : rdata_a;
            if (exp_rd_q.size() == 0) begin
               check("unexpected_rvalid", 32'({rvalid_a, rvalid_b}), 32'(0));
            end else begin
               er = exp_rd_q.pop_front();
               check("read_return", 32'({rvalid_a, rvalid_b, rd}), 32'({~er[8], er[8], er[7:0]}));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
   endtask

   task automatic set_b(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
   endtask

   task automatic idle();
      set_a(0, 0, '0, '0);
      set_b(0, 0, '0, '0);
   endtask

   // Called at the start of sweep cycle 0; checks n sweep cycles
   task automatic check_sweep(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("sweep", 32'({busy, ram_we, ram_addr, ram_data}), 32'({1'b1, 1'b1, 6'(i), 8'h00}));
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset with a request pending: rst must block grants and RAM writes
      rst = 1'b1;
      set_a(1, 1, 6'h05, 8'h99);
      repeat (3) step();
      @(negedge clk);
      check("rst_outputs", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we}), 32'(0));
`ifdef RAM_ARB_CLEAR_EN
      check("rst_busy", 32'(busy), 32'(1));
`else
      check("rst_busy", 32'(busy), 32'(0));
`endif
      idle();
      step();
      rst = 1'b0;

`ifdef RAM_ARB_CLEAR_EN
      // Sweep interrupted by rst at address 20, then a full 64-cycle sweep
      check_sweep(20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_sweep(64);
      @(negedge clk);
      check("sweep_done", 32'({busy, dbg_state}), 32'(2'b01));
      step();
      // Cleared words read back as zero
      set_a(1, 0, 6'd0, 8'h00);  exp_gnt(0, 0, 6'd0, 8'h00);  exp_rd(0, 8'h00); step();
      set_a(1, 0, 6'd31, 8'h00); exp_gnt(0, 0, 6'd31, 8'h00); exp_rd(0, 8'h00); step();
      set_a(1, 0, 6'd63, 8'h00); exp_gnt(0, 0, 6'd63, 8'h00); exp_rd(0, 8'h00); step();
      idle(); step();
`endif

      // A writes 0x5A to 0x10, then reads it back the next cycle
      set_a(1, 1, 6'h10, 8'h5A); exp_gnt(0, 1, 6'h10, 8'h5A);
`ifndef RAM_ARB_CLEAR_EN
      @(negedge clk);
      check("first_grant", 32'({busy, gnt_a}), 32'(2'b01));
`endif
      step();
      set_a(1, 0, 6'h10, 8'h00); exp_gnt(0, 0, 6'h10, 8'h00); exp_rd(0, 8'h5A); step();
      idle(); step();

      // Preload 0x02=0x11 (A) and 0x03=0x22 (B)
      set_a(1, 1, 6'h02, 8'h11); exp_gnt(0, 1, 6'h02, 8'h11); step();
      set_a(0, 0, '0, '0);
      set_b(1, 1, 6'h03, 8'h22); exp_gnt(1, 1, 6'h03, 8'h22); step();
      idle(); step();

      // Back-to-back reads with different tags
      set_a(1, 0, 6'h02, 8'h00); exp_gnt(0, 0, 6'h02, 8'h00); exp_rd(0, 8'h11); step();
      set_a(0, 0, '0, '0);
      set_b(1, 0, 6'h03, 8'h00); exp_gnt(1, 0, 6'h03, 8'h00); exp_rd(1, 8'h22); step();
      idle(); step();

      // Contention for 6 cycles: last grant was B, so A,B,A,B,A,B
      set_a(1, 0, 6'h10, 8'h00);
      set_b(1, 1, 6'h21, 8'hB2);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            exp_gnt(0, 0, 6'h10, 8'h00);
            exp_rd(0, 8'h5A);
         end else begin
            exp_gnt(1, 1, 6'h21, 8'hB2);
         end
         step();
      end
      idle(); step();

      // Same-address contention: A's write wins, B's read follows and sees it
      set_a(1, 1, 6'h30, 8'h77);
      set_b(1, 0, 6'h30, 8'h00);
      exp_gnt(0, 1, 6'h30, 8'h77); step();
      set_a(0, 0, '0, '0);
      exp_gnt(1, 0, 6'h30, 8'h00); exp_rd(1, 8'h77); step();
      idle(); step();

      // B's write loses and is withdrawn; it must leave 0x30 untouched
      set_a(1, 0, 6'h21, 8'h00);
      set_b(1, 1, 6'h30, 8'hEE);
      exp_gnt(0, 0, 6'h21, 8'h00); exp_rd(0, 8'hB2); step();
      set_b(0, 0, '0, '0);
      set_a(1, 0, 6'h30, 8'h00);
      exp_gnt(0, 0, 6'h30, 8'h00); exp_rd(0, 8'h77); step();
      idle(); step();

      // Request in the same cycle as rst: no grant, no read return afterwards
      set_a(1, 0, 6'h10, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("gnt_during_rst", 32'({gnt_a, gnt_b, ram_we}), 32'(0));
      step();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("rvalid_after_rst", 32'({rvalid_a, rvalid_b}), 32'(0));
      step();

      repeat (3) step();
      check("grant_queue_empty", 32'(exp_gnt_q.size()), 32'(0));
      check("read_queue_empty", 32'(exp_rd_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester controller that shares one single-port RAM (64 x 8 by default) between independent clients, for example the parser write path and the lookup read path. Grants at most one access per cycle with round-robin priority and drives the RAM's write-enable, address and data. It returns read data to the requester that issued the read, tagged with a one-cycle-delayed valid. An optional post-reset sweep clears every RAM word before normal traffic is accepted.

## Interface
- ADDR_WIDTH, 6: RAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: RAM data width.

- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_a / req_b  in  1  access request from client A / B.
- we_a / we_b  in  1  1 = write, 0 = read; qualified by req.
- addr_a / addr_b  in  ADDR_WIDTH  access address.
- wdata_a / wdata_b  in  DATA_WIDTH  write data.
- gnt_a / gnt_b  out  1  access accepted this cycle (combinational).
- rvalid_a / rvalid_b  out  1  read data valid this cycle (registered).
- rdata_a / rdata_b  out  DATA_WIDTH  read data; equals ram_q and is meaningful only while the matching rvalid is 1.
- busy  out  1  clear sweep in progress; no grants are issued while it is 1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_q  in  DATA_WIDTH  RAM read data; registered-address RAM, valid the cycle after the address is presented.

## Operation
- States: INIT (clear sweep) and RUN. Reset enters INIT when clear is compiled in, otherwise RUN.
- INIT behaviour:
  - An ADDR_WIDTH-bit counter starts at 0. Each cycle drives ram_we=1, ram_addr=counter, ram_data=0.
  - On counter = 2^ADDR_WIDTH-1, the FSM goes to RUN.
  - busy=1 and gnt_a=gnt_b=0 throughout INIT.
- RUN arbitration:
  - Only req_a set: grant A. Only req_b set: grant B. Neither set: no grant.
  - Both set: grant the client not granted most recently.
  - A 1-bit last_grant register updates on every grant.
- Handshake:
  - A transfer occurs in a cycle with req_x=1 and gnt_x=1.
  - A requester must hold req, we, addr and wdata stable until it is granted.
  - Deasserting req before grant withdraws the request; it is legal and has no side effects.
- RAM drive:
  - ram_addr and ram_data come from the granted client.
  - ram_we = granted client's we.
  - With no grant: ram_we=0, ram_addr=0, ram_data=0.
- Read return:
  - A granted read sets rvalid_x for exactly the next cycle.
  - rdata_a and rdata_b both follow ram_q.
- Fairness: a continuously requesting client is granted within 2 cycles.

## Timing
- Reset values: gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, ram_we=0, last_grant=B (so A wins the first contention).
- busy reset value is 1 with clear compiled in, 0 without.
- rst asserted mid-sweep or mid-traffic:
  - The sweep restarts at address 0.
  - Pending rvalid is dropped.
  - An access granted in the same cycle rst is high is not issued: gnt is forced 0 during rst.
- Clear sweep length: exactly 2^ADDR_WIDTH cycles after rst deasserts. The first grant is possible in cycle 2^ADDR_WIDTH, counting the first post-reset cycle as 0.
- Grant: combinational, same cycle as req. Throughput is one access per cycle, with back-to-back grants to either client.
- Read latency: grant in cycle N gives rvalid_x=1 and valid rdata_x in cycle N+1.
- Read-after-write: a write to address X in cycle N followed by a read of X in cycle N+1 returns the new data in cycle N+2.
- Simultaneous read and write requests to the same address: arbitration order decides. The loser's access happens a cycle later and sees the winner's effect.

## Configuration
- RAM_ARB_CLEAR_EN defined: the INIT sweep is compiled in; busy=1 after reset for 2^ADDR_WIDTH cycles.
- RAM_ARB_CLEAR_EN undefined: no INIT state or counter; reset goes directly to RUN; busy is tied 0. RAM contents after power-up are undefined.

## Test plan
- Clear sweep (macro on): release rst; busy=1 for exactly 64 cycles and ram_addr steps 0..63 with ram_we=1, ram_data=0. Reads of addresses 0, 31 and 63 then return 0x00.
- Single-client write/read: A writes 0x5A to 0x10 in cycle N, then reads 0x10 in N+1. gnt_a=1 both cycles; rvalid_a=1 and rdata_a=0x5A in N+2; rvalid_b stays 0.
- Contention: req_a and req_b held high for 6 cycles. Grant order is A,B,A,B,A,B; ram_addr alternates between addr_a and addr_b.
- Mixed read tags: A reads 0x02 (holding 0x11) and B reads 0x03 (holding 0x22) back-to-back. rvalid_a with 0x11, then rvalid_b with 0x22, on consecutive cycles; never both valid in the same cycle.
- Reset mid-sweep: assert rst at sweep address 20 for one cycle. The sweep restarts at 0 and busy lasts a full 64 cycles after release.
- Macro off: busy=0 from reset; A's request is granted in the first cycle after rst deasserts.
